// File: rtl/food_ctrl_pkg.sv
// Shared definitions for the food placement controller.
//   COORD_W     : width of every x/y coordinate on the playfield
//   SEG_MAX_DEF : default snake body RAM depth
//   state_t     : food placement FSM states
package food_ctrl_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned SEG_MAX_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SCAN,
    PLACE,
    HOLD
  } state_t;

endpackage

// File: rtl/food_ctrl_body_scan.sv
// Walks the snake body RAM and compares every segment with a candidate
// food position.
//   clk, rst       : clock, asynchronous active-high reset
//   go             : pulse in the cycle before the scan starts; loads len,
//                    rewinds the address to 0
//   active         : scan cycle in progress (address advances, compares valid)
//   len            : number of segments to visit (already clamped)
//   cand_x, cand_y : candidate position under test
//   body_x, body_y : RAM read data, one cycle behind addr
//   addr           : RAM read address; holds while not active
//   done           : last scan cycle (every segment compared)
//   hit            : the segment compared this cycle equals the candidate
module food_ctrl_body_scan
  import food_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               active,
  input  logic [6:0]         len,
  input  logic [COORD_W-1:0] cand_x,
  input  logic [COORD_W-1:0] cand_y,
  input  logic [COORD_W-1:0] body_x,
  input  logic [COORD_W-1:0] body_y,
  output logic [ADDR_W-1:0]  addr,
  output logic               done,
  output logic               hit
);

  // k is the scan cycle index: cycle k issues address k (if k < len) and
  // compares the data returned for address k-1 (if k > 0), so a scan of
  // len segments lasts len+1 cycles.
  logic [6:0] k;
  logic [6:0] len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k     <= '0;
      len_q <= '0;
      addr  <= '0;
    end else if (go) begin
      k     <= '0;
      len_q <= len;
      addr  <= '0;
    end else if (active) begin
      k <= k + 7'd1;
      if ((k + 7'd1) < len_q)
        addr <= ADDR_W'(k + 7'd1);
    end
  end

  assign done = active && (k == len_q);
  assign hit  = active && (k != 7'd0) && (body_x == cand_x) && (body_y == cand_y);

endmodule

// File: rtl/food_ctrl.sv
// Food placement controller: requests a random box position, rejects
// positions that overlap the snake body, publishes the accepted food and
// detects the head eating it.
//   clk, rst            : clock, asynchronous active-high reset
//   start               : pulse; (re)start food placement from any state
//   head_step           : pulse; head moved this cycle
//   head_x, head_y      : current head position
//   snake_len           : valid segment count (clamped to SEG_MAX)
//   body_addr           : body RAM read address, index 0 is the head
//   body_x, body_y      : body RAM data, one cycle after body_addr
//   drive               : one-cycle request to random_box
//   box_x, box_y        : candidate from random_box, BOX_LAT after drive
//   food_x, food_y      : accepted food position
//   food_valid          : food position is stable and displayable
//   eat                 : pulse; head reached the food
//   place_fail          : sticky; last placement was force-accepted
module food_ctrl
  import food_ctrl_pkg::*;
#(
  parameter int unsigned SEG_MAX   = SEG_MAX_DEF,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BOX_LAT   = 2,
  parameter int unsigned MAX_RETRY = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               head_step,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic [6:0]         snake_len,
  output logic [ADDR_W-1:0]  body_addr,
  input  logic [COORD_W-1:0] body_x,
  input  logic [COORD_W-1:0] body_y,
  output logic               drive,
  input  logic [COORD_W-1:0] box_x,
  input  logic [COORD_W-1:0] box_y,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               eat,
  output logic               place_fail
);

  state_t state, state_nxt;

  logic [3:0]         wcnt;
  logic [3:0]         retry;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic [6:0]         len_c;
  logic               wlast, exhaust, head_hit;
  logic               go, scan_active, scan_done, scan_hit;

  assign len_c    = (snake_len > 7'(SEG_MAX)) ? 7'(SEG_MAX) : snake_len;
  assign wlast    = (wcnt == 4'(BOX_LAT - 1));
  assign exhaust  = ((retry + 4'd1) == 4'(MAX_RETRY));
  assign head_hit = head_step && (head_x == food_x) && (head_y == food_y);

  // A start during SCAN freezes the address so it holds its last value.
  assign scan_active = (state == SCAN) && !start;

  food_ctrl_body_scan #(
    .ADDR_W (ADDR_W)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .active (scan_active),
    .len    (len_c),
    .cand_x (cand_x),
    .cand_y (cand_y),
    .body_x (body_x),
    .body_y (body_y),
    .addr   (body_addr),
    .done   (scan_done),
    .hit    (scan_hit)
  );

  always_comb begin
    state_nxt = state;
    eat       = 1'b0;
    go        = 1'b0;
    if (start) begin
      state_nxt = REQ;
    end else begin
      unique case (state)
        IDLE:  state_nxt = IDLE;
        REQ:   state_nxt = WAIT;
        WAIT: begin
          if (wlast) begin
            go        = 1'b1;
            state_nxt = SCAN;
          end
        end
        SCAN: begin
          // A hit on the final compare still counts as a collision.
          if (scan_hit)
            state_nxt = exhaust ? PLACE : REQ;
          else if (scan_done)
            state_nxt = PLACE;
        end
        PLACE: state_nxt = HOLD;
        HOLD: begin
          if (head_hit) begin
            eat       = 1'b1;
            state_nxt = REQ;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Decoded from state so that an asynchronous reset drops them at once.
  assign drive      = (state == REQ);
  assign food_valid = (state == HOLD) && !eat && !start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wcnt       <= '0;
      retry      <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      food_x     <= '0;
      food_y     <= '0;
      place_fail <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= ((state == WAIT) && (state_nxt == WAIT)) ? wcnt + 4'd1 : '0;
      if (go) begin
        cand_x <= box_x;
        cand_y <= box_y;
      end
      if (start) begin
        retry      <= '0;
        place_fail <= 1'b0;
      end else if ((state == SCAN) && scan_hit) begin
        retry <= retry + 4'd1;
        if (exhaust)
          place_fail <= 1'b1;
      end else if (eat) begin
        retry <= '0;
      end
      if ((state == PLACE) && !start) begin
        food_x <= cand_x;
        food_y <= cand_y;
      end
    end
  end

endmodule

// File: tb/tb_food_ctrl.sv
module tb_food_ctrl;

  localparam int unsigned SEG_MAX   = 64;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned BOX_LAT   = 2;
  localparam int unsigned MAX_RETRY = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       head_step = 1'b0;
  logic [9:0] head_x = '0, head_y = '0;
  logic [6:0] snake_len = '0;
  logic [5:0] body_addr;
  logic [9:0] body_x, body_y;
  logic       drive;
  logic [9:0] box_x = '0, box_y = '0;
  logic [9:0] food_x, food_y;
  logic       food_valid, eat, place_fail;

  always #5 clk = ~clk;

  food_ctrl #(
    .SEG_MAX   (SEG_MAX),
    .ADDR_W    (ADDR_W),
    .BOX_LAT   (BOX_LAT),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .head_step  (head_step),
    .head_x     (head_x),
    .head_y     (head_y),
    .snake_len  (snake_len),
    .body_addr  (body_addr),
    .body_x     (body_x),
    .body_y     (body_y),
    .drive      (drive),
    .box_x      (box_x),
    .box_y      (box_y),
    .food_x     (food_x),
    .food_y     (food_y),
    .food_valid (food_valid),
    .eat        (eat),
    .place_fail (place_fail)
  );

  // Body RAM model: registered read, data one cycle after the address.
  logic [9:0] ram_x [64];
  logic [9:0] ram_y [64];
  always @(posedge clk) begin
    body_x <= ram_x[body_addr];
    body_y <= ram_y[body_addr];
  end

  // random_box model: garbage right after drive, real candidate only once
  // BOX_LAT cycles have elapsed since drive was sampled.
  typedef struct packed { logic [9:0] x; logic [9:0] y; } pt_t;
  typedef struct packed { logic [9:0] x; logic [9:0] y; logic fail; } exp_t;
  pt_t  cand_q [$];
  pt_t  def_pt = '{x: 10'd500, y: 10'd500};
  pt_t  bp;
  int   box_cnt = 0;
  int   drv_cnt = 0;

  always @(negedge clk) begin
    if (drive) begin
      box_x   = 10'h3FF;
      box_y   = 10'h3FF;
      box_cnt = BOX_LAT;
    end else if (box_cnt > 0) begin
      box_cnt = box_cnt - 1;
      if (box_cnt == 0) begin
        if (cand_q.size() > 0) bp = cand_q.pop_front();
        else                   bp = def_pt;
        box_x = bp.x;
        box_y = bp.y;
      end
    end
  end

  always @(negedge clk) if (drive) drv_cnt = drv_cnt + 1;

  // Scoreboard of expected placements, popped when food_valid rises.
  exp_t exp_q [$];
  exp_t e;

  int n_vec = 0;
  int n_mis = 0;
  int cyc;
  int drv_base;
  bit to;

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_food(input int max_cyc, output int c, output bit t);
    c = 0;
    t = 1'b0;
    while (!food_valid) begin
      if (c >= max_cyc) begin
        t = 1'b1;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({drive, food_valid, eat, place_fail, food_x, food_y, body_addr} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got drv=%b fv=%b eat=%b pf=%b food=(%0d,%0d) addr=%0d required all 0",
               drive, food_valid, eat, place_fail, food_x, food_y, body_addr);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    snake_len = 7'd3;
    cand_q.push_back('{x: 10'd200, y: 10'd150});
    exp_q.push_back('{x: 10'd200, y: 10'd150, fail: 1'b0});
    drv_base = drv_cnt;
    pulse_start();
    n_vec++;
    if (drive !== 1'b1) begin
      n_mis++; $display("FAIL basic_drive_after_start: got %b required 1", drive);
    end
    wait_food(50, cyc, to);
    n_vec++;
    if (to || cyc != 8) begin
      n_mis++; $display("FAIL basic_latency: got %0d cycles (timeout=%b) required 8", cyc, to);
    end
    n_vec++;
    if (drv_cnt - drv_base != 1) begin
      n_mis++; $display("FAIL basic_drive_count: got %0d required 1", drv_cnt - drv_base);
    end
    e = exp_q.pop_front();
    n_vec++;
    if ({food_x, food_y, place_fail} !== {e.x, e.y, e.fail}) begin
      n_mis++;
      $display("FAIL basic_food: got (%0d,%0d,pf=%b) required (%0d,%0d,pf=%b)",
               food_x, food_y, place_fail, e.x, e.y, e.fail);
    end
  endtask

  task automatic test_collision();
    cand_q.push_back('{x: 10'd90,  y: 10'd100});
    cand_q.push_back('{x: 10'd300, y: 10'd200});
    exp_q.push_back('{x: 10'd300, y: 10'd200, fail: 1'b0});
    drv_base = drv_cnt;
    pulse_start();
    wait_food(80, cyc, to);
    n_vec++;
    if (to || cyc != 14) begin
      n_mis++; $display("FAIL collision_latency: got %0d cycles (timeout=%b) required 14", cyc, to);
    end
    n_vec++;
    if (drv_cnt - drv_base != 2) begin
      n_mis++; $display("FAIL collision_drive_count: got %0d required 2", drv_cnt - drv_base);
    end
    e = exp_q.pop_front();
    n_vec++;
    if ({food_x, food_y, place_fail} !== {e.x, e.y, e.fail}) begin
      n_mis++;
      $display("FAIL collision_food: got (%0d,%0d,pf=%b) required (%0d,%0d,pf=%b)",
               food_x, food_y, place_fail, e.x, e.y, e.fail);
    end
  endtask

  task automatic test_exhaust();
    def_pt = '{x: 10'd100, y: 10'd100};
    exp_q.push_back('{x: 10'd100, y: 10'd100, fail: 1'b1});
    drv_base = drv_cnt;
    pulse_start();
    wait_food(200, cyc, to);
    n_vec++;
    if (to || cyc != 41) begin
      n_mis++; $display("FAIL exhaust_latency: got %0d cycles (timeout=%b) required 41", cyc, to);
    end
    n_vec++;
    if (drv_cnt - drv_base != MAX_RETRY) begin
      n_mis++; $display("FAIL exhaust_drive_count: got %0d required %0d", drv_cnt - drv_base, MAX_RETRY);
    end
    e = exp_q.pop_front();
    n_vec++;
    if ({food_x, food_y, place_fail} !== {e.x, e.y, e.fail}) begin
      n_mis++;
      $display("FAIL exhaust_food: got (%0d,%0d,pf=%b) required (%0d,%0d,pf=%b)",
               food_x, food_y, place_fail, e.x, e.y, e.fail);
    end
    def_pt = '{x: 10'd500, y: 10'd500};
  endtask

  // Eats the forced food (place_fail stays set), then restarts mid-scan.
  task automatic test_restart_midscan();
    snake_len = 7'd40;
    cand_q.push_back('{x: 10'd700, y: 10'd700});
    cand_q.push_back('{x: 10'd710, y: 10'd710});
    exp_q.push_back('{x: 10'd710, y: 10'd710, fail: 1'b0});
    head_x = 10'd100; head_y = 10'd100; head_step = 1'b1;
    #1;
    n_vec++;
    if (eat !== 1'b1) begin
      n_mis++; $display("FAIL restart_eat_forced_food: got %b required 1", eat);
    end
    @(posedge clk); #1 head_step = 1'b0;
    cyc = 0;
    while (body_addr != 6'd10 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (body_addr !== 6'd10 || place_fail !== 1'b1) begin
      n_mis++; $display("FAIL restart_reach_idx10: got addr=%0d pf=%b required addr=10 pf=1", body_addr, place_fail);
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_vec++;
    if ({drive, body_addr, place_fail, food_valid} !== {1'b1, 6'd10, 1'b0, 1'b0}) begin
      n_mis++;
      $display("FAIL restart_abort: got drv=%b addr=%0d pf=%b fv=%b required drv=1 addr=10 pf=0 fv=0",
               drive, body_addr, place_fail, food_valid);
    end
    wait_food(150, cyc, to);
    n_vec++;
    if (to || cyc != 45) begin
      n_mis++; $display("FAIL restart_latency: got %0d cycles (timeout=%b) required 45", cyc, to);
    end
    e = exp_q.pop_front();
    n_vec++;
    if ({food_x, food_y, place_fail} !== {e.x, e.y, e.fail}) begin
      n_mis++;
      $display("FAIL restart_food: got (%0d,%0d,pf=%b) required (%0d,%0d,pf=%b)",
               food_x, food_y, place_fail, e.x, e.y, e.fail);
    end
  endtask

  task automatic test_rst_in_wait();
    snake_len = 7'd3;
    cand_q.push_back('{x: 10'd701, y: 10'd701});
    pulse_start();
    @(posedge clk); #1;
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if ({drive, food_valid, eat, place_fail, food_x, food_y, body_addr} !== '0) begin
      n_mis++;
      $display("FAIL rst_in_wait: got drv=%b fv=%b eat=%b pf=%b food=(%0d,%0d) addr=%0d required all 0",
               drive, food_valid, eat, place_fail, food_x, food_y, body_addr);
    end
    drv_base = drv_cnt;
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (drv_cnt - drv_base != 0 || food_valid !== 1'b0) begin
      n_mis++; $display("FAIL rst_no_drive: got drives=%0d fv=%b required 0 0", drv_cnt - drv_base, food_valid);
    end
  endtask

  task automatic test_eat();
    cand_q.push_back('{x: 10'd200, y: 10'd150});
    exp_q.push_back('{x: 10'd200, y: 10'd150, fail: 1'b0});
    pulse_start();
    wait_food(50, cyc, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || {food_x, food_y, place_fail} !== {e.x, e.y, e.fail}) begin
      n_mis++;
      $display("FAIL eat_setup_food: got (%0d,%0d,pf=%b) timeout=%b required (%0d,%0d,pf=%b)",
               food_x, food_y, place_fail, to, e.x, e.y, e.fail);
    end
    cand_q.push_back('{x: 10'd400, y: 10'd300});
    exp_q.push_back('{x: 10'd400, y: 10'd300, fail: 1'b0});
    head_x = 10'd210; head_y = 10'd150; head_step = 1'b1;
    #1;
    n_vec++;
    if ({eat, food_valid} !== 2'b01) begin
      n_mis++; $display("FAIL eat_miss: got eat=%b fv=%b required eat=0 fv=1", eat, food_valid);
    end
    @(posedge clk); #1;
    head_x = 10'd200;
    #1;
    n_vec++;
    if ({eat, food_valid} !== 2'b10) begin
      n_mis++; $display("FAIL eat_hit: got eat=%b fv=%b required eat=1 fv=0", eat, food_valid);
    end
    @(posedge clk); #1 head_step = 1'b0;
    n_vec++;
    if ({eat, drive} !== 2'b01) begin
      n_mis++; $display("FAIL eat_next_cycle: got eat=%b drv=%b required eat=0 drv=1", eat, drive);
    end
    head_step = 1'b1;
    #1;
    n_vec++;
    if (eat !== 1'b0) begin
      n_mis++; $display("FAIL eat_outside_hold: got %b required 0", eat);
    end
    @(posedge clk); #1 head_step = 1'b0;
    wait_food(50, cyc, to);
    e = exp_q.pop_front();
    n_vec++;
    if (to || {food_x, food_y, place_fail} !== {e.x, e.y, e.fail}) begin
      n_mis++;
      $display("FAIL eat_replace_food: got (%0d,%0d,pf=%b) timeout=%b required (%0d,%0d,pf=%b)",
               food_x, food_y, place_fail, to, e.x, e.y, e.fail);
    end
  endtask

  task automatic test_edge_len();
    logic [63:0] seen;
    // Empty snake: one scan cycle, candidate accepted.
    snake_len = 7'd0;
    cand_q.push_back('{x: 10'd5, y: 10'd5});
    exp_q.push_back('{x: 10'd5, y: 10'd5, fail: 1'b0});
    pulse_start();
    wait_food(30, cyc, to);
    n_vec++;
    if (to || cyc != 5) begin
      n_mis++; $display("FAIL len0_latency: got %0d cycles (timeout=%b) required 5", cyc, to);
    end
    e = exp_q.pop_front();
    n_vec++;
    if ({food_x, food_y, place_fail} !== {e.x, e.y, e.fail}) begin
      n_mis++;
      $display("FAIL len0_food: got (%0d,%0d,pf=%b) required (%0d,%0d,pf=%b)",
               food_x, food_y, place_fail, e.x, e.y, e.fail);
    end
    // Full snake: every address 0..63 visited.
    snake_len = 7'd64;
    cand_q.push_back('{x: 10'd800, y: 10'd800});
    exp_q.push_back('{x: 10'd800, y: 10'd800, fail: 1'b0});
    pulse_start();
    seen = '0;
    cyc  = 0;
    while (!food_valid && cyc < 200) begin
      seen[body_addr] = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    n_vec++;
    if (!food_valid || cyc != 69) begin
      n_mis++; $display("FAIL len64_latency: got %0d cycles fv=%b required 69", cyc, food_valid);
    end
    n_vec++;
    if (seen !== {64{1'b1}}) begin
      n_mis++; $display("FAIL len64_addr_walk: got seen=%h required all ones", seen);
    end
    e = exp_q.pop_front();
    n_vec++;
    if ({food_x, food_y, place_fail} !== {e.x, e.y, e.fail}) begin
      n_mis++;
      $display("FAIL len64_food: got (%0d,%0d,pf=%b) required (%0d,%0d,pf=%b)",
               food_x, food_y, place_fail, e.x, e.y, e.fail);
    end
    // Oversized length clamps to SEG_MAX.
    snake_len = 7'd100;
    cand_q.push_back('{x: 10'd810, y: 10'd810});
    exp_q.push_back('{x: 10'd810, y: 10'd810, fail: 1'b0});
    pulse_start();
    wait_food(200, cyc, to);
    n_vec++;
    if (to || cyc != 69) begin
      n_mis++; $display("FAIL len_clamp_latency: got %0d cycles (timeout=%b) required 69", cyc, to);
    end
    e = exp_q.pop_front();
    n_vec++;
    if ({food_x, food_y, place_fail} !== {e.x, e.y, e.fail}) begin
      n_mis++;
      $display("FAIL len_clamp_food: got (%0d,%0d,pf=%b) required (%0d,%0d,pf=%b)",
               food_x, food_y, place_fail, e.x, e.y, e.fail);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_x[i] = 10'(i);
      ram_y[i] = 10'd600;
    end
    ram_x[0] = 10'd100; ram_y[0] = 10'd100;
    ram_x[1] = 10'd90;  ram_y[1] = 10'd100;
    ram_x[2] = 10'd80;  ram_y[2] = 10'd100;

    test_reset();
    test_basic();
    test_collision();
    test_exhaust();
    test_restart_midscan();
    test_rst_in_wait();
    test_eat();
    test_edge_len();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
